// File: rtl/piece_board_probe.sv
// Tetromino probe: walks a piece's 4 shape rows against the playfield RAM.
// Reports collisions and optionally locks the piece; PROBE_EARLY_EXIT_EN enables early check exit.
module piece_board_probe #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int ROW_AW  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               op_lock,
    input  logic [2:0]         pc_type,
    input  logic [1:0]         pc_rot,
    input  logic [4:0]         pc_x,
    input  logic [5:0]         pc_y,
    output logic [2:0]         shp_type,
    output logic [1:0]         shp_rot,
    input  logic [15:0]        shp_rows,
    output logic               brd_ren,
    output logic [ROW_AW-1:0]  brd_raddr,
    input  logic [BOARD_W-1:0] brd_rdata,
    output logic               brd_we,
    output logic [ROW_AW-1:0]  brd_waddr,
    output logic [BOARD_W-1:0] brd_wdata,
    output logic               busy,
    output logic               done,
    output logic               collide
);

    typedef enum logic [1:0] {IDLE, ROW_RD, ROW_EV, DONE} state_t;

    state_t state, state_n;

    logic [1:0]  k;
    logic [2:0]  c_type;
    logic [1:0]  c_rot;
    logic [4:0]  c_x;
    logic [5:0]  c_y;
    logic        c_lock;
    logic [15:0] c_rows;
    logic        acc;

    logic [3:0]         bits;
    logic [6:0]         r;
    logic [6:0]         col;
    logic [BOARD_W-1:0] mask;
    logic               oob;
    logic               r_neg;
    logic               r_low;

    logic               acc_set;
    logic               row_end;
    logic               k_inc;

    assign bits  = c_rows[4*k +: 4];
    assign r     = {c_y[5], c_y} + {5'd0, k};
    assign r_neg = r[6];
    assign r_low = r >= 7'(BOARD_H);

    // Column offsets are resolved at 7-bit signed width so both walls see every bit.
    always_comb begin
        mask = '0;
        oob  = 1'b0;
        col  = '0;
        for (int j = 0; j < 4; j++) begin
            col = {{2{c_x[4]}}, c_x} + 7'(j);
            if (bits[j]) begin
                if (col[6] || col >= 7'(BOARD_W)) begin
                    oob = 1'b1;
                end
                for (int c = 0; c < BOARD_W; c++) begin
                    if (col == 7'(c)) begin
                        mask[c] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_n   = state;
        acc_set   = 1'b0;
        row_end   = 1'b0;
        k_inc     = 1'b0;
        brd_ren   = 1'b0;
        brd_raddr = '0;
        brd_we    = 1'b0;
        brd_waddr = '0;
        brd_wdata = '0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = ROW_RD;
                end
            end
            ROW_RD: begin
                if (bits == 4'd0 || r_neg) begin
                    row_end = 1'b1;
                end else if (oob || r_low) begin
                    acc_set = 1'b1;
                    row_end = 1'b1;
                end else begin
                    brd_ren   = 1'b1;
                    brd_raddr = r[ROW_AW-1:0];
                    state_n   = ROW_EV;
                end
            end
            ROW_EV: begin
                acc_set = |(brd_rdata & mask);
                row_end = 1'b1;
                if (c_lock) begin
                    brd_we    = 1'b1;
                    brd_waddr = r[ROW_AW-1:0];
                    brd_wdata = brd_rdata | mask;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (row_end) begin
            k_inc   = 1'b1;
            state_n = (k == 2'd3) ? DONE : ROW_RD;
`ifdef PROBE_EARLY_EXIT_EN
            if (acc_set && !c_lock) begin
                state_n = DONE;
            end
`endif
        end

        // Board strobes are suppressed in the reset cycle itself.
        if (rst) begin
            brd_ren = 1'b0;
            brd_we  = 1'b0;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            c_type <= '0;
            c_rot  <= '0;
            c_x    <= '0;
            c_y    <= '0;
            c_lock <= 1'b0;
            c_rows <= '0;
            acc    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                c_type <= pc_type;
                c_rot  <= pc_rot;
                c_x    <= pc_x;
                c_y    <= pc_y;
                c_lock <= op_lock;
                c_rows <= shp_rows;
                k      <= '0;
                acc    <= 1'b0;
            end else begin
                if (k_inc) begin
                    k <= k + 2'd1;
                end
                if (acc_set) begin
                    acc <= 1'b1;
                end
            end
        end
    end

    assign busy     = (state != IDLE);
    assign collide  = acc;
    assign shp_type = (state == IDLE) ? pc_type : c_type;
    assign shp_rot  = (state == IDLE) ? pc_rot : c_rot;

endmodule

// File: doc/piece_board_probe.md
Name: piece_board_probe

Overview:
- Sequential consumer of the tetromino shape lookup. It takes a piece (type, rotation, x, y), fetches that piece's 4 shape rows from the shape ROM interface, and walks them against the playfield RAM row by row.
- In check mode it reports whether the piece collides with the walls, the floor or settled cells.
- In lock mode it also ORs the piece cells into the playfield.
- It sits between the game-control FSM (which issues start/op and consumes done/collide) and the board RAM.

Parameters:
- BOARD_W, 10, playfield width in cells. Board word bit c = column c.
- BOARD_H, 20, playfield height in rows. Row 0 = top.
- ROW_AW, 5, board RAM row-address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  request pulse; accepted only when busy=0
- op_lock  in  1  0 = check only, 1 = check and lock; sampled with start
- pc_type  in  3  piece type 0..6
- pc_rot  in  2  rotation 0..3
- pc_x  in  5  signed two's-complement column of shape bit 0
- pc_y  in  6  signed two's-complement row of shape row 0
- shp_type  out  3  to shape ROM; equals pc_type in IDLE, captured value while busy
- shp_rot  out  2  to shape ROM; same rule as shp_type
- shp_rows  in  16  shape rows from ROM; row k = bits [4k+3:4k], bit j = column offset j
- brd_ren  out  1  board read enable
- brd_raddr  out  ROW_AW  board read row
- brd_rdata  in  BOARD_W  read data, valid the cycle after brd_ren (synchronous RAM)
- brd_we  out  1  board write enable
- brd_waddr  out  ROW_AW  board write row
- brd_wdata  out  BOARD_W  board write data
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- collide  out  1  result; valid when done=1, held until the next accepted start

Behaviour:
- Reset: state IDLE. busy, done, collide, brd_ren and brd_we are 0. Addresses and wdata are 0.
- Reset mid-operation aborts immediately. No brd_we is issued after the reset cycle.
- Start acceptance: IDLE with start=1 captures type, rot, x, y, op_lock and shp_rows in that cycle. Next cycle: busy=1, k=0, state ROW_RD. start is ignored while busy.
- Row k, board row r = pc_y + k, shifted mask M = shp_rows[k] placed at columns pc_x..pc_x+3.
- ROW_RD, row k:
  - Empty shape row, or r < 0: skip; the row takes 1 cycle, no read.
  - Any set cell in column < 0 or ≥ BOARD_W: set collide_acc; the row takes 1 cycle, no read.
  - r ≥ BOARD_H and row non-empty: set collide_acc; the row takes 1 cycle, no read.
  - Otherwise assert brd_ren with brd_raddr = r, go to ROW_EV.
- ROW_EV: if (brd_rdata & M) ≠ 0, set collide_acc.
  - If op_lock, assert brd_we, brd_waddr = r, brd_wdata = brd_rdata | M, in the same cycle.
  - The row takes 2 cycles in total.
- Row sequencing: after row k, k increments. After k=3 the block goes to DONE.
- Lock writes occur only on in-range rows. Lock writes even when collide_acc is set; the controller decides validity from collide.
- DONE, 1 cycle: done=1 and collide=collide_acc. Then IDLE, busy=0.
  - A start in the DONE cycle is ignored.
  - A start in the first IDLE cycle after DONE is accepted.
- Latency: done asserts 1 + Σ(row cost) cycles after the acceptance cycle. Row cost is 1 or 2, so latency is 5..9 cycles.
- Arithmetic: pc_y + k is computed at 7-bit signed width. Column placement uses at least BOARD_W+8 bits so no bit is lost at either wall.
- brd_ren and brd_we are never asserted in IDLE or DONE.

Optional Feature:
- Macro: PROBE_EARLY_EXIT_EN.
- Defined: in check mode (op_lock=0), the first collision detected in ROW_RD or ROW_EV goes directly to DONE. Remaining rows issue no reads, and latency shortens accordingly. Lock mode is unchanged.
- Undefined: all 4 rows are always walked.

Test Plan:
1. Empty board; type 2 (rows 0110,0110,0000,0000); x=3, y=0; check -> reads rows 0 and 1; no brd_we; done 7 cycles after acceptance; collide=0.
2. Type 1, rot 2 (row2 = 1111); x=7, y=0; empty board -> row 2 hits column 10, no read for it; collide=1; with PROBE_EARLY_EXIT_EN, done 4 cycles after acceptance.
3. Board row 5 = 0000011000 (columns 3,4); type 2 at x=3, y=4 -> row 5 mask has columns 4,5; collide=1.
4. Empty board; type 2, x=0, y=18, op_lock=1 -> writes row 18 = 0000000110 and row 19 = 0000000110; collide=0.
5. Type 2, x=0, y=19, lock -> row 20 is out of range, so collide=1; only row 19 is written; y=-1 -> row -1 skipped, row 0 read and written.
6. start pulsed while busy -> ignored, single done. rst asserted in the cycle after the first ROW_EV of a lock -> no brd_we in the following cycles, busy=0, next start processed normally.
